lut_cfg_loader: RTL and testbench
=================================

# lut_cfg_loader

Configuration sequencer for a bank of fracturable soft-coded LUTs. It accepts a byte-wide bitstream over a valid/ready stream and assembles one full LUT configuration word (two half-LUT truth tables plus the fracture bit) per LUT. It then writes each word into its target LUT with a single-cycle per-LUT enable, LUT 0 first. It sits between the CLB configuration port and the LUT array and shares one `config_in` bus among all LUTs.

## Interface
- `INPUTS`, 4, address bits per half-LUT.
- `MEM_SIZE`, 2**INPUTS, truth-table bits per half-LUT.
- `CFG_W`, 2*MEM_SIZE+1, configuration word width; MSB is the fracture bit.
- `NUM_LUTS`, 4, number of LUTs loaded per sequence; must be at least 1.
- `DATA_W`, 8, stream byte width.
- `BYTES_PER_LUT`, ceil(CFG_W/DATA_W), derived: 5 at defaults.

- `config_clk`  in  1  sole clock, rising edge.
- `config_rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begins a load sequence when sampled high in IDLE.
- `in_data`  in  DATA_W  bitstream byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `lut_config_in`  out  CFG_W  shared configuration bus to all LUTs.
- `lut_config_en`  out  NUM_LUTS  one-hot write strobe, one bit per LUT.
- `busy`  out  1  a sequence is in progress.
- `done`  out  1  last sequence completed.
- `err`  out  1  padding violation seen in last sequence.

## Operation
- States:
  - IDLE: `in_ready`=0, `busy`=0.
  - LOAD: `in_ready`=1, `busy`=1.
  - COMMIT: `in_ready`=0, `busy`=1.
  - DONE: `busy`=0, `done`=1.
- IDLE/DONE + `start`: clear `done`, clear `err`, clear the LUT index and byte counter, then go to LOAD.
- LOAD: a byte is accepted on `in_valid && in_ready`.
  - Bytes are LSB-first: byte k fills bits [k*DATA_W +: DATA_W] of the shift/assembly register.
  - After byte BYTES_PER_LUT-1 is accepted, go to COMMIT.
- Padding: bits of the final byte at positions ≥ CFG_W are discarded. If any of them is 1, set `err` (sticky until the next `start`). Loading continues.
- COMMIT, one cycle:
  - `lut_config_en[idx]`=1 and `lut_config_in` holds the assembled word.
  - Then `idx`++ and the byte counter clears.
  - If `idx` was NUM_LUTS-1, go to DONE; otherwise go to LOAD.
- `lut_config_en` is all-zero outside COMMIT. Exactly one bit is set in COMMIT.
- `lut_config_in` holds its value outside COMMIT (no glitching). It is all-zero after reset.
- `start` is ignored in LOAD and COMMIT.
- `in_valid` in IDLE, COMMIT or DONE is not accepted (`in_ready`=0). Data is held by the upstream source per valid/ready rules.

## Timing
- Reset values:
  - state IDLE.
  - `in_ready`, `busy`, `done`, `err` = 0.
  - `lut_config_en` = 0.
  - `lut_config_in` = 0.
- `config_rst` mid-sequence: return to IDLE next cycle with no strobe issued. LUTs already committed keep their contents; LUTs have no reset.
- `start` → LOAD: `in_ready` is high on the cycle after `start` is sampled.
- Last byte accepted at cycle t → `lut_config_en` high at t+1 only → `in_ready` high again at t+2, unless that was the last LUT.
- Back-to-back streaming: at best one byte per cycle, so a sequence takes NUM_LUTS*(BYTES_PER_LUT+1) cycles. That is 24 at defaults, from the first `in_ready` to `done`.
- Last LUT committed at t → `done`=1 and `busy`=0 at t+1. `done` holds until the next `start` or reset.
- `start` and `config_rst` asserted together: reset wins.

## Structure
- Shared package `clb_cfg_pkg` holds:
  - the state enum (IDLE, LOAD, COMMIT, DONE);
  - the CFG_W and BYTES_PER_LUT derivation functions, also used by the CLB-level bitstream generator and tests.
- One sub-module, `cfg_word_assembler`:
  - byte counter plus assembly register;
  - outputs `word`, `last_byte`, `pad_err`.
- FSM, LUT index and one-hot decode stay in the top module.

## Test plan
- Reset then `start`, stream 20 bytes continuously at defaults → four single-cycle strobes 0001, 0010, 0100, 1000 at cycles 6, 12, 18, 24 after the first `in_ready`. `done`=1 at cycle 25, `err`=0.
- LUT 2 word = 0x1_A5A5_3C3C sent as bytes 3C 3C A5 A5 01 → on the 0100 strobe, `lut_config_in` = 0x1_A5A5_3C3C (fracture bit 1).
- Final byte of LUT 1 = 0x03 (bit 33 set) → bit 33 dropped (word bit 32 = 1), `err`=1 at the end. A new `start` clears `err` to 0.
- Random `in_valid` deassertion during LOAD → identical words and strobe order, with no extra strobes.
- Assert `config_rst` after LUT 1 commits and mid-way through LUT 2 bytes → next cycle IDLE; `lut_config_en`, `in_ready`, `busy`, `done` = 0; no strobe to LUT 2.
- `start` pulsed during LOAD, and `in_valid` held high in IDLE/DONE → no state change, no bytes consumed.

Source files
------------

// File: rtl/clb_cfg_pkg.sv
// Shared CLB configuration definitions: loader state encoding and the
// LUT configuration word geometry used by the loader and bitstream tooling.
package clb_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMMIT,
        ST_DONE
    } cfg_state_e;

    // Two half-LUT truth tables plus the fracture bit.
    function automatic int cfg_width(input int mem_size);
        return 2 * mem_size + 1;
    endfunction

    function automatic int bytes_per_lut(input int cfg_w, input int data_w);
        return (cfg_w + data_w - 1) / data_w;
    endfunction

    function automatic int count_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cfg_word_assembler.sv
// Collects LSB-first stream bytes into one LUT configuration word and flags
// set padding bits in the final byte.
module cfg_word_assembler
    import clb_cfg_pkg::*;
#(
    parameter int CFG_W         = 33,
    parameter int DATA_W        = 8,
    parameter int BYTES_PER_LUT = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              accept,
    input  logic [DATA_W-1:0] in_data,
    output logic [CFG_W-1:0]  word,
    output logic              last_byte,
    output logic              pad_err
);

    localparam int ASM_W = BYTES_PER_LUT * DATA_W;
    localparam int CNT_W = count_width(BYTES_PER_LUT);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ASM_W-1:0] asm_q, asm_d;
    logic [ASM_W-1:0] merged;

    // merged already contains the byte being accepted, so the word is
    // complete in the same cycle the final byte arrives.
    always_comb begin
        merged = asm_q;
        for (int unsigned i = 0; i < BYTES_PER_LUT; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                merged[i*DATA_W +: DATA_W] = in_data;
            end
        end
        last_byte = accept && (cnt_q == CNT_W'(BYTES_PER_LUT - 1));
        asm_d     = accept ? merged : asm_q;
        cnt_d     = cnt_q;
        if (clear || last_byte) begin
            cnt_d = '0;
        end else if (accept) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign word = merged[CFG_W-1:0];

    generate
        if (ASM_W > CFG_W) begin : g_pad
            assign pad_err = last_byte && (|merged[ASM_W-1:CFG_W]);
        end else begin : g_no_pad
            assign pad_err = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            asm_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            asm_q <= asm_d;
        end
    end

endmodule

// File: rtl/lut_cfg_loader.sv
// Configuration sequencer: streams bytes into per-LUT configuration words and
// writes them LUT 0 first over a shared bus with a one-hot write strobe.
module lut_cfg_loader
    import clb_cfg_pkg::*;
#(
    parameter  int INPUTS        = 4,
    parameter  int NUM_LUTS      = 4,
    parameter  int DATA_W        = 8,
    localparam int MEM_SIZE      = 2 ** INPUTS,
    localparam int CFG_W         = cfg_width(MEM_SIZE),
    localparam int BYTES_PER_LUT = bytes_per_lut(CFG_W, DATA_W)
) (
    input  logic                config_clk,
    input  logic                config_rst,
    input  logic                start,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [CFG_W-1:0]    lut_config_in,
    output logic [NUM_LUTS-1:0] lut_config_en,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int IDX_W = count_width(NUM_LUTS);

    cfg_state_e          state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                in_ready_q, in_ready_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [CFG_W-1:0]    cfg_q, cfg_d;
    logic [NUM_LUTS-1:0] en_q, en_d;

    logic                accept;
    logic                asm_clear;
    logic [CFG_W-1:0]    word;
    logic                last_byte;
    logic                pad_err;

    assign accept = in_valid && in_ready_q;

    cfg_word_assembler #(
        .CFG_W        (CFG_W),
        .DATA_W       (DATA_W),
        .BYTES_PER_LUT(BYTES_PER_LUT)
    ) u_asm (
        .clk      (config_clk),
        .rst      (config_rst),
        .clear    (asm_clear),
        .accept   (accept),
        .in_data  (in_data),
        .word     (word),
        .last_byte(last_byte),
        .pad_err  (pad_err)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        done_d    = done_q;
        err_d     = err_q;
        cfg_d     = cfg_q;
        asm_clear = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    idx_d     = '0;
                    asm_clear = 1'b1;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (last_byte) begin
                    cfg_d   = word;
                    state_d = ST_COMMIT;
                    if (pad_err) begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_COMMIT: begin
                asm_clear = 1'b1;
                if (idx_q == IDX_W'(NUM_LUTS - 1)) begin
                    idx_d   = '0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they are registered.
        in_ready_d = (state_d == ST_LOAD);
        busy_d     = (state_d == ST_LOAD) || (state_d == ST_COMMIT);
        en_d       = '0;
        if (state_d == ST_COMMIT) begin
            for (int unsigned i = 0; i < NUM_LUTS; i++) begin
                en_d[i] = (idx_d == IDX_W'(i));
            end
        end
    end

    always_ff @(posedge config_clk) begin
        if (config_rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cfg_q      <= '0;
            en_q       <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cfg_q      <= cfg_d;
            en_q       <= en_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err           = err_q;
    assign lut_config_in = cfg_q;
    assign lut_config_en = en_q;

endmodule

// File: tb/tb_lut_cfg_loader.sv
// Directed-sequence bench with randomized bytes/valid, checked against a
// byte-arithmetic model of the expected configuration words.
module tb_lut_cfg_loader;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int CW  = 33;
    localparam int BPL = 5;

    logic          config_clk = 1'b0;
    logic          config_rst;
    logic          start;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [CW-1:0] lut_config_in;
    logic [N-1:0]  lut_config_en;
    logic          busy;
    logic          done;
    logic          err;

    lut_cfg_loader #(
        .INPUTS  (4),
        .NUM_LUTS(N),
        .DATA_W  (DW)
    ) dut (
        .config_clk   (config_clk),
        .config_rst   (config_rst),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .lut_config_in(lut_config_in),
        .lut_config_en(lut_config_en),
        .busy         (busy),
        .done         (done),
        .err          (err)
    );

    always #5 config_clk = ~config_clk;

    int cyc = 0;
    always @(posedge config_clk) cyc++;

    typedef struct {
        int            lut;
        logic [CW-1:0] word;
        int            cyc;
    } strobe_t;

    strobe_t strobes[$];
    strobe_t mon_s;

    always @(negedge config_clk) begin
        if (lut_config_en != '0) begin
            mon_s.lut = -1;
            if ($onehot(lut_config_en)) begin
                for (int i = 0; i < N; i++) begin
                    if (lut_config_en[i]) mon_s.lut = i;
                end
            end
            mon_s.word = lut_config_in;
            mon_s.cyc  = cyc;
            strobes.push_back(mon_s);
        end
    end

    int checks = 0;
    int passed = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge config_clk);
        #1;
    endtask

    logic [DW-1:0] bytes [N*BPL];

    // Model: word is the little-endian byte value modulo 2**CW; any value
    // at or above 2**CW means padding bits were set.
    function automatic longint byte_value(input int k);
        longint v = 0;
        for (int b = 0; b < BPL; b++) v += longint'(bytes[k*BPL+b]) << (DW * b);
        return v;
    endfunction

    function automatic logic [CW-1:0] exp_word(input int k);
        return CW'(byte_value(k) % (longint'(1) << CW));
    endfunction

    function automatic logic exp_err(input int nluts);
        logic e = 1'b0;
        for (int k = 0; k < nluts; k++) e |= (byte_value(k) >= (longint'(1) << CW));
        return e;
    endfunction

    task automatic fill_random(input bit clean_pad);
        for (int i = 0; i < N*BPL; i++) bytes[i] = DW'($urandom_range(0, 255));
        if (clean_pad) begin
            for (int k = 0; k < N; k++) bytes[k*BPL+BPL-1] &= 8'h01;
        end
    endtask

    task automatic do_start(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_ready_after_start"}, in_ready, 1);
        check({tag, "_busy_after_start"}, busy, 1);
        check({tag, "_done_cleared"}, done, 0);
        check({tag, "_err_cleared"}, err, 0);
    endtask

    task automatic stream(input string tag, input int nbytes, input bit rand_valid, input bit poke_start);
        int   idx    = 0;
        int   budget = 0;
        logic rdy;
        while (idx < nbytes && budget < 3000) begin
            in_valid = rand_valid ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_data  = bytes[idx];
            rdy      = in_ready;
            start    = poke_start && rdy && ($urandom_range(0, 3) == 0);
            @(posedge config_clk);
            if (in_valid && rdy) idx++;
            #1;
            budget++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        check({tag, "_bytes_streamed"}, idx, nbytes);
    endtask

    task automatic wait_done(input string tag);
        int budget = 0;
        while (!done && budget < 100) begin
            tick();
            budget++;
        end
        check({tag, "_done_reached"}, done, 1);
    endtask

    task automatic check_seq(input string tag, input bit timing, input int first);
        check({tag, "_strobe_count"}, strobes.size(), N);
        for (int k = 0; k < N && k < strobes.size(); k++) begin
            check($sformatf("%s_strobe%0d_lut", tag, k), strobes[k].lut, k);
            check($sformatf("%s_strobe%0d_word", tag, k), strobes[k].word, exp_word(k));
            if (timing)
                check($sformatf("%s_strobe%0d_cycle", tag, k),
                      strobes[k].cyc - first + 1, (k + 1) * (BPL + 1));
        end
        if (timing) check({tag, "_done_cycle"}, cyc - first + 1, N * (BPL + 1) + 1);
        check({tag, "_busy_end"}, busy, 0);
        check({tag, "_err_end"}, err, exp_err(N));
        check({tag, "_en_idle"}, lut_config_en, 0);
        check({tag, "_bus_held"}, lut_config_in, exp_word(N - 1));
    endtask

    initial begin
        int first;
        config_rst = 1'b1;
        start      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_en", lut_config_en, 0);
        check("rst_bus", lut_config_in, 0);
        config_rst = 1'b0;

        in_valid = 1'b1;
        in_data  = 8'hEE;
        repeat (3) tick();
        check("idle_valid_ready", in_ready, 0);
        check("idle_valid_busy", busy, 0);
        in_valid = 1'b0;

        // Continuous stream with a known LUT 2 word and padding bit in LUT 1.
        fill_random(1'b1);
        bytes[2*BPL+0] = 8'h3C;
        bytes[2*BPL+1] = 8'h3C;
        bytes[2*BPL+2] = 8'hA5;
        bytes[2*BPL+3] = 8'hA5;
        bytes[2*BPL+4] = 8'h01;
        bytes[1*BPL+4] = 8'h03;
        strobes.delete();
        do_start("s1");
        first = cyc;
        stream("s1", N*BPL, 1'b0, 1'b0);
        wait_done("s1");
        check_seq("s1", 1'b1, first);
        check("s1_err_direct", err, 1);
        if (strobes.size() > 2) begin
            check("s1_lut2_word", strobes[2].word, 33'h1_A5A5_3C3C);
            check("s1_lut1_bit32", strobes[1].word[32], 1);
        end

        in_valid = 1'b1;
        repeat (3) tick();
        check("done_valid_ready", in_ready, 0);
        check("done_hold", done, 1);
        check("done_no_strobe", strobes.size(), N);
        in_valid = 1'b0;

        // Random valid gaps and start pokes during LOAD.
        fill_random(1'b0);
        strobes.delete();
        do_start("s2");
        stream("s2", N*BPL, 1'b1, 1'b1);
        wait_done("s2");
        check_seq("s2", 1'b0, 0);

        fill_random(1'b1);
        strobes.delete();
        do_start("s3");
        stream("s3", N*BPL, 1'b1, 1'b0);
        wait_done("s3");
        check_seq("s3", 1'b0, 0);

        // Reset partway through LUT 2.
        fill_random(1'b1);
        strobes.delete();
        do_start("s4");
        stream("s4", 2*BPL + 2, 1'b1, 1'b0);
        config_rst = 1'b1;
        tick();
        config_rst = 1'b0;
        check("rst_mid_ready", in_ready, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_en", lut_config_en, 0);
        repeat (5) tick();
        check("rst_mid_strobes", strobes.size(), 2);
        for (int k = 0; k < 2 && k < strobes.size(); k++) begin
            check($sformatf("rst_mid_strobe%0d_lut", k), strobes[k].lut, k);
            check($sformatf("rst_mid_strobe%0d_word", k), strobes[k].word, exp_word(k));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
